// File: rtl/wb_slave_mux.sv
// Wishbone address decoder and registered response multiplexer for NSLV peripherals.
// Misses and hung slaves are terminated with ERR_WORD, so the master never stalls.
module wb_slave_mux #(
    parameter int                                   NSLV     = 4,
    parameter int                                   DW       = 32,
    parameter int                                   AW       = 32,
    parameter int                                   DEC_HI   = 31,
    parameter int                                   DEC_LO   = 20,
    parameter logic [NSLV*(DEC_HI-DEC_LO+1)-1:0]    SLV_BASE = {12'h303, 12'h302, 12'h301, 12'h300},
    parameter int                                   TIMEOUT  = 255,
    parameter logic [DW-1:0]                        ERR_WORD = 32'hDEAD_BEEF
) (
    input  logic                 wb_clk_i,
    input  logic                 rst_n,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_we_i,
    input  logic [DW/8-1:0]      wbs_sel_i,
    input  logic [AW-1:0]        wbs_adr_i,
    input  logic [DW-1:0]        wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [DW-1:0]        wbs_dat_o,
    output logic                 err_o,
    output logic [7:0]           err_cnt_o,
    output logic [NSLV-1:0]      s_stb_o,
    output logic [NSLV-1:0]      s_cyc_o,
    output logic                 s_we_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    input  logic [NSLV-1:0]      s_ack_i,
    input  logic [NSLV*DW-1:0]   s_dat_i
);

    localparam int DECW = DEC_HI - DEC_LO + 1;
    localparam int SELW = (NSLV > 1) ? $clog2(NSLV) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state_q, state_d;
    logic [SELW-1:0]     sel_q;
    logic                we_q;
    logic [DW/8-1:0]     bsel_q;
    logic [AW-1:0]       adr_q;
    logic [DW-1:0]       dat_q;
    logic [DW-1:0]       rdat_q;
    logic [15:0]         cnt_q;
    logic                err_q;
    logic [7:0]          err_cnt_q;
    logic                guard_q;

    logic                valid;
    logic                hit;
    logic [SELW-1:0]     hit_idx;
    logic                ack_sel;
    logic                tmo;

    assign valid   = wbs_stb_i & wbs_cyc_i;
    assign ack_sel = s_ack_i[sel_q];
    assign tmo     = (cnt_q == 16'(TIMEOUT - 1));

    // Descending scan so the lowest matching window is the last assignment and wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (wbs_adr_i[DEC_HI:DEC_LO] == SLV_BASE[i*DECW +: DECW]) begin
                hit     = 1'b1;
                hit_idx = SELW'(i);
            end
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (valid && !guard_q) state_d = hit ? BUSY : RESP;
            BUSY: begin
                if (!valid)                state_d = IDLE;
                else if (ack_sel || tmo)   state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous here.
    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!rst_n) begin
            sel_q     <= '0;
            we_q      <= 1'b0;
            bsel_q    <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            rdat_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            guard_q   <= 1'b0;
        end else begin
            // Blocks decode in the IDLE cycle right after RESP so a lingering stb is not re-taken.
            guard_q <= (state_q == RESP);
            case (state_q)
                IDLE: begin
                    if (valid && !guard_q) begin
                        sel_q  <= hit_idx;
                        we_q   <= wbs_we_i;
                        bsel_q <= wbs_sel_i;
                        adr_q  <= wbs_adr_i;
                        dat_q  <= wbs_dat_i;
                        cnt_q  <= '0;
                        err_q  <= ~hit;
                        if (!hit) rdat_q <= ERR_WORD;
                    end
                end
                BUSY: begin
                    if (valid) begin
                        cnt_q <= cnt_q + 16'd1;
                        if (ack_sel) begin
                            rdat_q <= s_dat_i[int'(sel_q)*DW +: DW];
                            err_q  <= 1'b0;
                        end else if (tmo) begin
                            rdat_q <= ERR_WORD;
                            err_q  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        s_stb_o = '0;
        if (state_q == BUSY) s_stb_o[sel_q] = 1'b1;
    end

    assign s_cyc_o   = s_stb_o;
    assign s_we_o    = we_q;
    assign s_sel_o   = bsel_q;
    assign s_adr_o   = adr_q;
    assign s_dat_o   = dat_q;
    assign wbs_ack_o = (state_q == RESP);
    assign err_o     = (state_q == RESP) & err_q;
    assign wbs_dat_o = rdat_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: doc/wb_slave_mux.md
# wb_slave_mux

Parametrised Wishbone address decoder and response multiplexer that sits between the management-SoC Wishbone slave port of the user project wrapper and up to NSLV user peripherals (SDRAM controller, UART, DMA, …). It decodes each master cycle against per-slave address windows and forwards it to exactly one slave. It returns that slave's ack and read data through a registered path. Unmapped addresses and hung slaves are terminated with an error word, so the master never stalls.

## Interface
- NSLV, 4: number of slave channels (1–8).
- DW, 32: data width.
- AW, 32: address width.
- DEC_HI, 31 / DEC_LO, 20: address bit range compared against the window bases.
- SLV_BASE, {12'h303,12'h302,12'h301,12'h300}: packed bases, (DEC_HI-DEC_LO+1) bits per slave; slave i occupies slice i.
- TIMEOUT, 255: BUSY cycles without a slave ack before forced termination (1–65535).
- ERR_WORD, 32'hDEAD_BEEF: read data returned on a miss or timeout.
- wb_clk_i  in  1  sole clock.
- rst_n  in  1  synchronous active-low reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  master strobe, cycle and write-enable.
- wbs_sel_i  in  DW/8  byte selects.
- wbs_adr_i  in  AW  address.
- wbs_dat_i  in  DW  write data.
- wbs_ack_o  out  1  one-cycle acknowledge to the master.
- wbs_dat_o  out  DW  registered read data.
- err_o  out  1  pulses together with wbs_ack_o on a miss or timeout.
- err_cnt_o  out  8  saturating count of error terminations.
- s_stb_o, s_cyc_o  out  NSLV  per-slave strobe and cycle.
- s_we_o  out  1  shared write-enable.
- s_sel_o  out  DW/8  shared byte selects.
- s_adr_o  out  AW  shared address.
- s_dat_o  out  DW  shared write data.
- s_ack_i  in  NSLV  per-slave acknowledges.
- s_dat_i  in  NSLV*DW  per-slave read data; slave i occupies slice i.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE, valid = stb&cyc:
  - Compute the hit vector: wbs_adr_i[DEC_HI:DEC_LO] == base slice i.
  - Lowest matching index wins. Latch it as sel_q.
  - Latch we, sel, adr and dat into shadow registers.
  - Clear the timeout counter.
- IDLE -> BUSY on a hit.
- IDLE -> RESP on a miss, with dat=ERR_WORD and err flag set.
- BUSY:
  - s_stb_o[sel_q] and s_cyc_o[sel_q] are 1; all other bits are 0.
  - Shared s_* outputs come from the shadow registers, not from the live master bus.
  - Counter increments each cycle.
  - On s_ack_i[sel_q]: capture the s_dat_i slice into wbs_dat_o and go to RESP.
  - When the counter reaches TIMEOUT-1 with no ack: dat=ERR_WORD, err flag set, go to RESP.
  - Ack has priority over timeout in the same cycle.
- RESP:
  - wbs_ack_o=1 and err_o equals the err flag, for exactly one cycle.
  - err_cnt_o increments when the err flag is set and saturates at 255.
  - Go to IDLE.
- Acks from unselected slaves, and any s_ack_i outside BUSY, are ignored.
- wbs_dat_o holds its last value until the next capture. For writes it still carries the captured slave bus value.
- If the master drops stb/cyc while in BUSY: abort, deassert the slave strobes, return to IDLE with no ack and no error.
- rst_n=0 at any clock edge, including mid-transaction:
  - FSM -> IDLE.
  - All s_stb_o/s_cyc_o, wbs_ack_o and err_o = 0.
  - wbs_dat_o = 0, err_cnt_o = 0.
  - Shadow registers and counter cleared.

## Timing
- Decode is registered. The slave strobe rises 1 cycle after the master strobe is first sampled.
- Master-visible latency = 1 (decode) + N (slave ack cycles, ≥1) + 1 (RESP).
  - Zero-wait slave: ack on the 3rd edge after stb.
  - Miss: ack on the 2nd edge.
  - Timeout: ack on cycle 1 + TIMEOUT + 1.
- The master is expected to drop stb the cycle after the ack. IDLE does not re-decode in the cycle immediately after RESP (one-cycle guard), so a lingering stb is never taken as a new request.
- Back-to-back transfers: the minimum spacing is 4 cycles, ack to next ack.

## Test plan
- Read hit: adr=0x3010_0004, slave 1 acks after 2 cycles with 0x1234_5678 -> s_stb_o=4'b0010 for 2 cycles, wbs_ack_o one cycle with wbs_dat_o=0x1234_5678, err_o=0.
- Write to slave 0 (0x3000_0000, dat 0xA5A5_0001, sel=4'hF) -> s_dat_o/s_sel_o/s_we_o match and stay stable through BUSY even when the master bus changes; one ack is returned.
- Miss: adr=0x2000_0000 -> ack 2 cycles after stb, wbs_dat_o=0xDEAD_BEEF, err_o=1, err_cnt_o=1, no s_stb_o asserted.
- Timeout with TIMEOUT=8 and slave 2 silent -> s_stb_o[2] high for 8 cycles, then ack with ERR_WORD and err_o=1. A slave 2 ack arriving after that is ignored.
- Overlapping windows (bases 0 and 1 both 0x300) -> slave 0 is selected. Simultaneous ack and timeout -> slave data returned, err_o=0.
- rst_n low for 1 cycle while in BUSY -> all outputs 0 next cycle, err_cnt_o=0. A subsequent read to slave 3 completes normally. 300 misses -> err_cnt_o saturates at 255.
